pipe_carry_adder: RTL

Parametrised, pipelined ripple-carry adder that extends the single-bit full adder to WIDTH-bit operands. Operands are split into SEG-bit segments, one segment per pipeline stage, with a registered carry between stages, a valid/ready handshake, and optional signed saturation. It is the shared arithmetic primitive for message accumulation in the LDPC check/variable-node datapaths.

---
 rtl/pipe_carry_adder.sv | 115 +++++++++++
 1 files changed

// File: rtl/pipe_carry_adder.sv
// Pipelined ripple-carry adder: SEG bits per stage, registered inter-stage carry,
// valid/ready flow control with a single global advance, optional signed saturation.
module pipe_carry_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned Stages = WIDTH / SEG;

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < Stages; k++) begin : g_stage
    logic [WIDTH-1:0] src_x, src_y, src_sum;
    logic             src_c, src_v, src_sat, src_xm, src_ym;
    logic [SEG:0]     seg_add;
    logic [WIDTH-1:0] seg_ext;

    logic             valid_q, carry_q, sat_q, xmsb_q, ymsb_q;
    logic [WIDTH-1:0] sum_q;

    if (k == 0) begin : g_src
      assign src_x   = x;
      assign src_y   = y;
      assign src_sum = '0;
      assign src_c   = c_in;
      assign src_v   = in_valid;
      assign src_sat = sat_en;
      assign src_xm  = x[WIDTH-1];
      assign src_ym  = y[WIDTH-1];
    end else begin : g_src
      assign src_x   = g_stage[k-1].g_ops.opx_q;
      assign src_y   = g_stage[k-1].g_ops.opy_q;
      assign src_sum = g_stage[k-1].sum_q;
      assign src_c   = g_stage[k-1].carry_q;
      assign src_v   = g_stage[k-1].valid_q;
      assign src_sat = g_stage[k-1].sat_q;
      assign src_xm  = g_stage[k-1].xmsb_q;
      assign src_ym  = g_stage[k-1].ymsb_q;
    end

    // Operands are shifted down each stage, so the live segment is always the low SEG bits.
    assign seg_add = {1'b0, src_x[SEG-1:0]} + {1'b0, src_y[SEG-1:0]} + {{SEG{1'b0}}, src_c};
    assign seg_ext = WIDTH'(seg_add[SEG-1:0]) << (k * SEG);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sat_q   <= 1'b0;
        xmsb_q  <= 1'b0;
        ymsb_q  <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= src_v;
        carry_q <= seg_add[SEG];
        sat_q   <= src_sat;
        xmsb_q  <= src_xm;
        ymsb_q  <= src_ym;
        sum_q   <= src_sum | seg_ext;
      end
    end

    // The last stage has no higher-order segments left to skew.
    if (k < Stages - 1) begin : g_ops
      logic [WIDTH-1:0] opx_q, opy_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          opx_q <= '0;
          opy_q <= '0;
        end else if (adv) begin
          opx_q <= src_x >> SEG;
          opy_q <= src_y >> SEG;
        end
      end
    end
  end

  logic [WIDTH-1:0] raw_sum;
  logic             last_sat, last_xm, last_ym;

  assign out_valid = g_stage[Stages-1].valid_q;
  assign raw_sum   = g_stage[Stages-1].sum_q;
  assign c_out     = g_stage[Stages-1].carry_q;
  assign last_sat  = g_stage[Stages-1].sat_q;
  assign last_xm   = g_stage[Stages-1].xmsb_q;
  assign last_ym   = g_stage[Stages-1].ymsb_q;

  assign ovf = (last_xm == last_ym) && (raw_sum[WIDTH-1] != last_xm);

  always_comb begin
    s = raw_sum;
    if (last_sat && ovf) begin
      s = last_xm ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule
